// File: rtl/bus_1x16_loader_19bit.sv
// Bus loader: captures a shared 19-bit bus value into one of 16 registers
// through an IDLE -> WRITE -> ACK handshake, with a registered read port.
module bus_1x16_loader_19bit #(
    parameter int DATA_W = 19,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              d3,
    input  logic              d2,
    input  logic              d1,
    input  logic              d0,
    input  logic              wr_req,
    output logic              busy,
    output logic              wr_ack,
    input  logic [3:0]        rd_sel,
    output logic [DATA_W-1:0] rd_data,
    output logic [3:0]        last_dest,
    output logic [CNT_W-1:0]  wr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              load_hold;
    logic              do_write;
    logic [DATA_W-1:0] hold_data;
    logic [3:0]        hold_dest;
    logic [DATA_W-1:0] regs [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Requests are only looked at in IDLE, so anything arriving mid-handshake is dropped.
    always_comb begin
        next_state = state;
        load_hold  = 1'b0;
        do_write   = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    load_hold  = 1'b1;
                    next_state = WRITE;
                end
            end
            WRITE: begin
                do_write   = 1'b1;
                busy       = 1'b1;
                next_state = ACK;
            end
            ACK: begin
                busy       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
            hold_dest <= '0;
            rd_data   <= '0;
            last_dest <= '0;
            wr_count  <= '0;
            wr_ack    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // Non-blocking read of the array gives read-before-write on a shared index.
            rd_data <= regs[rd_sel];
            wr_ack  <= do_write;
            if (load_hold) begin
                hold_data <= bus_data;
                hold_dest <= {d3, d2, d1, d0};
            end
            if (do_write) begin
                regs[hold_dest] <= hold_data;
                last_dest       <= hold_dest;
                if (wr_count != '1) begin
                    wr_count <= wr_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_1x16_loader_19bit.sv
// Bench for bus_1x16_loader_19bit: directed scenarios plus random traffic,
// all checked against a transaction-level model built from edge timestamps.
module tb_bus_1x16_loader_19bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [18:0] bus_data = '0;
    logic        d3 = 1'b0;
    logic        d2 = 1'b0;
    logic        d1 = 1'b0;
    logic        d0 = 1'b0;
    logic        wr_req = 1'b0;
    logic        busy;
    logic        wr_ack;
    logic [3:0]  rd_sel = '0;
    logic [18:0] rd_data;
    logic [3:0]  last_dest;
    logic [7:0]  wr_count;

    int vector_count = 0;
    int miss_count = 0;

    // Reference model: register contents plus edge timestamps of the handshake.
    logic [18:0] m_regs [16];
    logic [18:0] m_rd;
    logic [18:0] pend_data;
    logic [3:0]  pend_dest;
    int          m_last;
    int          m_count;
    logic        m_ack;
    logic        m_busy;
    int          edge_n;
    int          write_edge;
    int          accept_edge;
    int          next_accept;

    bus_1x16_loader_19bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_data  (bus_data),
        .d3        (d3),
        .d2        (d2),
        .d1        (d1),
        .d0        (d0),
        .wr_req    (wr_req),
        .busy      (busy),
        .wr_ack    (wr_ack),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .last_dest (last_dest),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_rd        = '0;
        m_last      = 0;
        m_count     = 0;
        m_ack       = 1'b0;
        m_busy      = 1'b0;
        write_edge  = -1;
        accept_edge = -10;
        next_accept = edge_n;
    endtask

    // Predicts the effect of the coming rising edge given the inputs now applied.
    task automatic modelEdge(input logic req, input logic [18:0] data, input logic [3:0] dest, input logic [3:0] rsel);
        m_rd  = m_regs[rsel];
        m_ack = 1'b0;
        if (write_edge == edge_n) begin
            m_regs[pend_dest] = pend_data;
            m_last = int'(pend_dest);
            if (m_count < 255) m_count++;
            m_ack = 1'b1;
        end
        if (req && edge_n >= next_accept) begin
            pend_data   = data;
            pend_dest   = dest;
            accept_edge = edge_n;
            write_edge  = edge_n + 1;
            next_accept = edge_n + 3;
        end
        m_busy = (edge_n == accept_edge) || (edge_n == accept_edge + 1);
        edge_n++;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".rd_data"}, 32'(rd_data), 32'(m_rd));
        checkOutput({tag, ".wr_ack"}, 32'(wr_ack), 32'(m_ack));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(m_busy));
        checkOutput({tag, ".last_dest"}, 32'(last_dest), 32'(m_last));
        checkOutput({tag, ".wr_count"}, 32'(wr_count), 32'(m_count));
    endtask

    task automatic applyStimulus(input string tag, input logic req, input logic [18:0] data,
                                 input logic [3:0] dest, input logic [3:0] rsel);
        wr_req   = req;
        bus_data = data;
        {d3, d2, d1, d0} = dest;
        rd_sel   = rsel;
        modelEdge(req, data, dest, rsel);
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic doReset();
        wr_req = 1'b0;
        rst_n  = 1'b0;
        #1;
        modelReset();
        checkAll("reset_async");
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset_held");
        rst_n = 1'b1;
    endtask

    initial begin
        edge_n = 0;
        modelReset();
        #2;
        doReset();

        // Single write to index 3.
        applyStimulus("single_acc", 1'b1, 19'h5A5A5, 4'h3, 4'h3);
        applyStimulus("single_wr", 1'b0, 19'h0, 4'h0, 4'h3);
        checkOutput("single_ack", 32'(wr_ack), 32'd1);
        applyStimulus("single_ackdone", 1'b0, 19'h0, 4'h0, 4'h3);
        checkOutput("single_rd", 32'(rd_data), 32'h5A5A5);
        checkOutput("single_last", 32'(last_dest), 32'd3);
        checkOutput("single_cnt", 32'(wr_count), 32'd1);

        // Held request: only edges k and k+3 are accepted.
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus("held", 1'b1, 19'h00010 + 19'(i), 4'hF, 4'hF);
        end
        repeat (3) applyStimulus("held_idle", 1'b0, 19'h0, 4'h0, 4'hF);
        checkOutput("held_cnt", 32'(wr_count), 32'd2);
        checkOutput("held_reg15", 32'(rd_data), 32'h00013);

        // Read-before-write on index 7.
        applyStimulus("rbw_pre", 1'b1, 19'h00001, 4'h7, 4'h7);
        applyStimulus("rbw_pre", 1'b0, 19'h0, 4'h0, 4'h7);
        applyStimulus("rbw_pre", 1'b0, 19'h0, 4'h0, 4'h7);
        applyStimulus("rbw_acc", 1'b1, 19'h7FFFF, 4'h7, 4'h7);
        applyStimulus("rbw_wr", 1'b0, 19'h0, 4'h0, 4'h7);
        checkOutput("rbw_old", 32'(rd_data), 32'h00001);
        applyStimulus("rbw_after", 1'b0, 19'h0, 4'h0, 4'h7);
        checkOutput("rbw_new", 32'(rd_data), 32'h7FFFF);

        // Counter saturation.
        doReset();
        for (int i = 0; i < 260; i++) begin
            applyStimulus("sat", 1'b1, 19'($urandom), 4'h0, 4'h0);
            applyStimulus("sat", 1'b0, 19'h0, 4'h0, 4'h0);
            applyStimulus("sat", 1'b0, 19'h0, 4'h0, 4'h0);
        end
        checkOutput("sat_cnt", 32'(wr_count), 32'd255);

        // Reset while in WRITE aborts the pending write to index 9.
        doReset();
        applyStimulus("midrst_acc", 1'b1, 19'h4BCDE, 4'h9, 4'h9);
        checkOutput("midrst_busy", 32'(busy), 32'd1);
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus("midrst_after", 1'b0, 19'h0, 4'h0, 4'h9);
            checkOutput("midrst_reg9", 32'(rd_data), 32'd0);
            checkOutput("midrst_ack", 32'(wr_ack), 32'd0);
        end

        // Isolation: every index written, then read back.
        for (int i = 0; i < 16; i++) begin
            applyStimulus("iso_wr", 1'b1, 19'h12345, 4'(i), 4'(i));
            applyStimulus("iso_wr", 1'b0, 19'h0, 4'h0, 4'(i));
            applyStimulus("iso_wr", 1'b0, 19'h0, 4'h0, 4'(i));
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus("iso_rd", 1'b0, 19'h0, 4'h0, 4'(i));
            checkOutput("iso_val", 32'(rd_data), 32'h12345);
        end

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus("rand", 1'($urandom), 19'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule

// File: doc/bus_1x16_loader_19bit.md
BUS_1X16_LOADER_19BIT -- requirements
Module: bus_1x16_loader_19bit

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; all state SHALL clear when rst_n is low, independent of clk.
REQ-002 The block SHALL have the following parameters (name, default, meaning), and SHALL be verified at defaults only:
- DATA_W, 19: bus and register width.
- CNT_W, 8: write-counter width.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- bus_data, in, 19: shared CPU bus value to be stored.
- d3,d2,d1,d0, in, 1 each: destination register select, {d3,d2,d1,d0}, d3 = MSB.
- wr_req, in, 1: write request, level-sampled in IDLE.
- busy, out, 1: high while in WRITE or ACK.
- wr_ack, out, 1: one-cycle completion pulse.
- rd_sel, in, 4: read-port register select.
- rd_data, out, 19: registered read data.
- last_dest, out, 4: destination index of the most recent completed write.
- wr_count, out, 8: saturating count of completed writes.

Function
REQ-004 The block SHALL contain 16 storage registers, reg0..reg15, each 19 bits wide, mirroring the 16 sources of the 16:1 bus select.
REQ-005 The FSM SHALL have states IDLE, WRITE and ACK, and SHALL enter IDLE on reset.
REQ-006 In IDLE, when wr_req=1 at a rising edge, the FSM SHALL:
- load hold_data <= bus_data and hold_dest <= {d3,d2,d1,d0};
- go to WRITE.
REQ-007 In IDLE, when wr_req=0, the FSM SHALL remain in IDLE with no register change.
REQ-008 In WRITE, the FSM SHALL, at the next edge, write reg[hold_dest] <= hold_data, set last_dest <= hold_dest and wr_ack <= 1, and go to ACK.
REQ-009 In ACK, the FSM SHALL, at the next edge, set wr_ack <= 0 and go to IDLE.
REQ-010 The FSM SHALL ignore wr_req while in WRITE or ACK; no request SHALL be queued.
REQ-011 Timing SHALL be as follows, for a request accepted at edge k:
- the register update is visible at edge k+1;
- wr_ack is high for exactly the cycle between edges k+1 and k+2;
- the earliest next acceptance is edge k+3 (maximum throughput one write per 3 cycles).
REQ-012 busy SHALL be a decode of the state (WRITE or ACK) with no extra latency.
REQ-013 bus_data and d3..d0 SHALL be sampled only at the accepting edge; later changes SHALL NOT affect the write in progress.
REQ-014 rd_data SHALL update at every rising edge to reg[rd_sel].
REQ-015 On a same-edge read and write of the same index, rd_data SHALL return the old value, and the new value SHALL appear one edge later (read-before-write).
REQ-016 wr_count SHALL increment by 1 at each WRITE->ACK transition, SHALL saturate at 255, and SHALL NOT wrap.
REQ-017 Exactly one register SHALL change per completed write; the other 15 SHALL hold their values.

Reset
REQ-018 On rst_n=0, the following SHALL be set:
- reg0..reg15 = 0;
- rd_data = 0, last_dest = 0, wr_count = 0;
- wr_ack = 0, busy = 0, state = IDLE.
REQ-019 Reset asserted in WRITE or ACK SHALL abort the operation, with no register write and no wr_ack pulse after release.
REQ-020 After rst_n deasserts, the first request SHALL be accepted no earlier than the first rising edge with rst_n=1.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Single write: bus_data=19'h5A5A5, d=4'h3, wr_req pulsed one cycle -> reg3=19'h5A5A5 at k+1; wr_ack high one cycle; last_dest=3; wr_count=1; busy high for 2 cycles.
- Held request: wr_req held high for 6 cycles, bus_data incrementing from 19'h00010, d=4'hF -> writes accepted at k and k+3 only; wr_count=2; reg15 holds the bus value sampled at k+3.
- Read-before-write: rd_sel=4'h7 while reg7 (19'h00001) is overwritten with 19'h7FFFF -> rd_data=19'h00001 on the write edge, then 19'h7FFFF on the next edge.
- Counter saturation: 260 writes to d=4'h0 -> wr_count=255; no wrap-around.
- Mid-operation reset: rst_n=0 during WRITE for d=4'h9 -> reg9=0, wr_ack never asserts, all outputs 0, state IDLE.
- Isolation: write 19'h12345 to every index 0..15 in turn, then read back all 16 via rd_sel -> each index returns its own value.
